// File: rtl/exp_datapath.sv
// exp_datapath
// Fixed-point datapath for the iterative Taylor-series exponential unit.
// Computes r = sum_{k=0..TERMS} x^k / k! in unsigned Q(DW-FRAC).FRAC,
// driven by the one-hot-per-cycle control strobes of the exponential
// controller. Holds the x, t (current term), r (accumulator) and c (term
// counter) registers; no FSM of its own.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   x_in                 operand x
//   zx, ldx              clear / load x
//   zt, initt, ldt       clear / set 1.0 / load product into t
//   zr, initr, ldr       clear / set 1.0 / accumulate t into r
//   zc, enc              clear / increment term counter (wraps TERMS-1 -> 0)
//   s                    multiplier operand select: 0 = x, 1 = coef[c]
//   co                   counter terminal, c == TERMS-1
//   r_out, t_out, c_out  register contents
//
// Register priority: clear > init > load.
//
// Configuration macro EXP_SAT_EN: when defined, the multiplier output and
// the r accumulation saturate to 2^DW-1 on overflow; otherwise both wrap
// modulo 2^DW.

module exp_datapath #(
    parameter int unsigned DW    = 16,
    parameter int unsigned FRAC  = 14,
    parameter int unsigned TERMS = 8,
    parameter int unsigned CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] x_in,
    input  logic          zx,
    input  logic          ldx,
    input  logic          zt,
    input  logic          initt,
    input  logic          ldt,
    input  logic          zr,
    input  logic          initr,
    input  logic          ldr,
    input  logic          zc,
    input  logic          enc,
    input  logic          s,
    output logic          co,
    output logic [DW-1:0] r_out,
    output logic [DW-1:0] t_out,
    output logic [CW-1:0] c_out
);

    localparam logic [DW-1:0] One     = DW'(32'd1 << FRAC);
    localparam logic [CW-1:0] LastCnt = CW'(TERMS - 1);

    logic [DW-1:0] x_q, x_d;
    logic [DW-1:0] t_q, t_d;
    logic [DW-1:0] r_q, r_d;
    logic [CW-1:0] c_q, c_d;

    // Reciprocal ROM: coef[k] = round(2^FRAC / (k+1)), 1/(k+1) for the k-th term.
    logic [DW-1:0] coef [TERMS];

    for (genvar k = 0; k < TERMS; k++) begin : g_coef
        localparam int unsigned Div     = k + 1;
        localparam int unsigned CoefVal = ((32'd1 << FRAC) + Div / 2) / Div;
        assign coef[k] = CoefVal[DW-1:0];
    end

    logic [DW-1:0]   mul_op;
    logic [2*DW-1:0] prod;
    logic [DW-1:0]   mult;
    logic [DW:0]     sum;
    logic [DW-1:0]   acc;
    logic            unused_bits;

    // Truncating multiply (floor) and accumulate.
    always_comb begin
        mul_op = s ? coef[c_q] : x_q;
        prod   = {{DW{1'b0}}, t_q} * {{DW{1'b0}}, mul_op};
        sum    = {1'b0, r_q} + {1'b0, t_q};
`ifdef EXP_SAT_EN
        mult        = (|prod[2*DW-1:FRAC+DW]) ? {DW{1'b1}} : prod[FRAC+DW-1:FRAC];
        acc         = sum[DW] ? {DW{1'b1}} : sum[DW-1:0];
        unused_bits = ^prod[FRAC-1:0];
`else
        mult        = prod[FRAC+DW-1:FRAC];
        acc         = sum[DW-1:0];
        unused_bits = ^{prod[2*DW-1:FRAC+DW], prod[FRAC-1:0], sum[DW]};
`endif
    end

    // Next-state selection, clear > init > load for every register.
    always_comb begin
        x_d = x_q;
        if (zx) begin
            x_d = '0;
        end else if (ldx) begin
            x_d = x_in;
        end

        t_d = t_q;
        if (zt) begin
            t_d = '0;
        end else if (initt) begin
            t_d = One;
        end else if (ldt) begin
            t_d = mult;
        end

        r_d = r_q;
        if (zr) begin
            r_d = '0;
        end else if (initr) begin
            r_d = One;
        end else if (ldr) begin
            r_d = acc;
        end

        c_d = c_q;
        if (zc) begin
            c_d = '0;
        end else if (enc) begin
            c_d = (c_q == LastCnt) ? '0 : c_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            t_q <= '0;
            r_q <= '0;
            c_q <= '0;
        end else begin
            x_q <= x_d;
            t_q <= t_d;
            r_q <= r_d;
            c_q <= c_d;
        end
    end

    assign co    = (c_q == LastCnt);
    assign r_out = r_q;
    assign t_out = t_q;
    assign c_out = c_q;

endmodule
